// File: rtl/sample_link_tx.sv
// sample_link_tx: FIFO-buffered source end of the 8-bit parallel sample link.
// Each word is presented on link_data with a flop-generated strobe link_clk:
// SETUP cycles low, HIGH cycles high, GAP cycles low, with the data held throughout.
module sample_link_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SETUP = 2,
  parameter int unsigned HIGH  = 2,
  parameter int unsigned GAP   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               link_data,
  output logic                     link_clk,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned MAX_SH = (SETUP > HIGH) ? SETUP : HIGH;
  localparam int unsigned MAX_P  = (MAX_SH > GAP) ? MAX_SH : GAP;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    link_data_q;
  logic          link_clk_q;
  logic          busy_q;
  logic          push_c;
  logic          pop_c;
  logic          expire_c;
  logic          nonempty_c;

  // Handshake and status decode from registered occupancy
  assign in_ready   = (level_q != LW'(DEPTH));
  assign push_c     = in_valid && in_ready;
  assign nonempty_c = (level_q != LW'(0));
  assign expire_c   = (cnt_q == CW'(1));

  assign link_data = link_data_q;
  assign link_clk  = link_clk_q;
  assign busy      = busy_q;
  assign level     = level_q;

  // Next-state, phase counter reload and pop decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nonempty_c) begin
          pop_c   = 1'b1;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP);
        end
      end
      S_SETUP: begin
        if (expire_c) begin
          state_d = S_HIGH;
          cnt_d   = CW'(HIGH);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (expire_c) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (expire_c) begin
          if (nonempty_c) begin
            // back-to-back words go straight to the next setup window
            pop_c   = 1'b1;
            state_d = S_SETUP;
            cnt_d   = CW'(SETUP);
          end else begin
            state_d = S_IDLE;
            cnt_d   = CW'(0);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    level_d = level_q;
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset since pointers and level are cleared
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // State, pointers and registered link outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= CW'(0);
      wr_ptr_q    <= AW'(0);
      rd_ptr_q    <= AW'(0);
      level_q     <= LW'(0);
      link_data_q <= 8'h00;
      link_clk_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      link_clk_q <= (state_d == S_HIGH);
      busy_q     <= (state_d != S_IDLE) || (level_d != LW'(0));
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        link_data_q <= mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_sample_link_tx.sv
// Directed bench for sample_link_tx: default-timing instance plus a
// SETUP=1/HIGH=3/GAP=1 instance, strobe activity captured by monitors.
module tb_sample_link_tx;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] link_data;
  logic       link_clk;
  logic       busy;
  logic [2:0] level;

  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] link_data2;
  logic       link_clk2;
  logic       busy2;
  logic [2:0] level2;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  sample_link_tx #(.DEPTH(4), .SETUP(2), .HIGH(2), .GAP(2)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .link_data(link_data),
    .link_clk (link_clk),
    .busy     (busy),
    .level    (level)
  );

  sample_link_tx #(.DEPTH(4), .SETUP(1), .HIGH(3), .GAP(1)) u_dut2 (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data2),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .link_data(link_data2),
    .link_clk (link_clk2),
    .busy     (busy2),
    .level    (level2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running cycle counter for strobe spacing
  always @(posedge clock) cyc <= cyc + 1;

  int         rise_cyc1[$];
  logic [7:0] rise_dat1[$];
  int         hi_w1[$];
  int         hi_run1 = 0;
  logic       prev1 = 1'b0;
  int         rise_cyc2[$];
  logic [7:0] rise_dat2[$];
  int         hi_w2[$];
  int         hi_run2 = 0;
  logic       prev2 = 1'b0;

  // Strobe monitor, default instance: rise time, data at rise, high width
  always @(negedge clock) begin
    if (link_clk) hi_run1 <= hi_run1 + 1;
    else if (hi_run1 != 0) begin
      hi_w1.push_back(hi_run1);
      hi_run1 <= 0;
    end
    if (link_clk && !prev1) begin
      rise_cyc1.push_back(cyc);
      rise_dat1.push_back(link_data);
    end
    prev1 <= link_clk;
  end

  // Strobe monitor, swept-timing instance
  always @(negedge clock) begin
    if (link_clk2) hi_run2 <= hi_run2 + 1;
    else if (hi_run2 != 0) begin
      hi_w2.push_back(hi_run2);
      hi_run2 <= 0;
    end
    if (link_clk2 && !prev2) begin
      rise_cyc2.push_back(cyc);
      rise_dat2.push_back(link_data2);
    end
    prev2 <= link_clk2;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cyc1.delete(); rise_dat1.delete(); hi_w1.delete();
    rise_cyc2.delete(); rise_dat2.delete(); hi_w2.delete();
  endtask

  logic [7:0] exp_q[$];
  int         accepted;

  initial begin
    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data2  = 8'h00;
    in_valid2 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_link_clk",  32'(link_clk),  32'd0);
    chk("rst_link_data", 32'(link_data), 32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b1;
    tick();
    clear_mon();

    // Single word 0xA5, push at edge 0
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sw_e0_level", 32'(level), 32'd1);
    chk("sw_e0_busy",  32'(busy),  32'd1);
    chk("sw_e0_data",  32'(link_data), 32'd0);
    tick();
    chk("sw_e1_data",  32'(link_data), 32'hA5);
    chk("sw_e1_clk",   32'(link_clk),  32'd0);
    chk("sw_e1_level", 32'(level),     32'd0);
    tick();
    chk("sw_e2_clk", 32'(link_clk), 32'd0);
    tick();
    chk("sw_e3_clk", 32'(link_clk), 32'd1);
    tick();
    chk("sw_e4_clk", 32'(link_clk), 32'd1);
    tick();
    chk("sw_e5_clk", 32'(link_clk), 32'd0);
    tick();
    chk("sw_e6_busy", 32'(busy), 32'd1);
    tick();
    chk("sw_e7_busy", 32'(busy), 32'd0);
    chk("sw_e7_data", 32'(link_data), 32'hA5);
    repeat (3) tick();
    clear_mon();

    // Back-to-back 0x01, 0x02, 0x03
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (22) tick();
    chk("b2b_rises", 32'(rise_cyc1.size()), 32'd3);
    chk("b2b_highs", 32'(hi_w1.size()),     32'd3);
    if (rise_cyc1.size() == 3 && hi_w1.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_data",  32'(rise_dat1[i]), 32'(i + 1));
        chk("b2b_width", 32'(hi_w1[i]),     32'd2);
      end
      chk("b2b_space01", 32'(rise_cyc1[1] - rise_cyc1[0]), 32'd6);
      chk("b2b_space12", 32'(rise_cyc1[2] - rise_cyc1[1]), 32'd6);
    end
    chk("b2b_idle", 32'(busy), 32'd0);
    clear_mon();

    // Full / backpressure: incrementing byte every cycle for 30 cycles
    exp_q.delete();
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      in_data  = 8'(8'h10 + i);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back(in_data);
        accepted++;
      end
      tick();
      chk("bp_level_le4", 32'(level <= 3'd4), 32'd1);
      if (i == 3) chk("bp_ready_e3", 32'(in_ready), 32'd1);
      if (i == 4) begin
        chk("bp_ready_e4", 32'(in_ready), 32'd0);
        chk("bp_level_e4", 32'(level),    32'd4);
        chk("bp_acc_e4",   32'(accepted), 32'd5);
      end
    end
    in_valid = 1'b0;
    repeat (80) tick();
    chk("bp_count", 32'(rise_dat1.size()), 32'(exp_q.size()));
    if (rise_dat1.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) chk("bp_order", 32'(rise_dat1[i]), 32'(exp_q[i]));
    end
    chk("bp_idle", 32'(busy), 32'd0);
    clear_mon();

    // Simultaneous push+pop at level 2 across 10 words
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h40 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pp_level_start", 32'(level), 32'd2);
    repeat (4) tick();
    for (int j = 0; j < 7; j++) begin
      chk("pp_level_pre", 32'(level), 32'd2);
      in_data = 8'(8'h43 + j); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("pp_level_post", 32'(level), 32'd2);
      repeat (5) tick();
    end
    repeat (30) tick();
    chk("pp_count", 32'(rise_dat1.size()), 32'd10);
    if (rise_dat1.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("pp_order", 32'(rise_dat1[i]), 32'(8'h40 + i));
    end
    clear_mon();

    // Mid-word reset during HIGH of 0x3C with two words queued
    in_data = 8'h3C; in_valid = 1'b1; tick();
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    chk("mr_level_q", 32'(level), 32'd2);
    tick();
    chk("mr_high",      32'(link_clk),  32'd1);
    chk("mr_high_data", 32'(link_data), 32'h3C);
    reset = 1'b0;
    #1;
    chk("mr_clk",   32'(link_clk),  32'd0);
    chk("mr_data",  32'(link_data), 32'd0);
    chk("mr_level", 32'(level),     32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_ready", 32'(in_ready),  32'd1);
    tick();
    reset = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("mr_no_strobe", 32'(rise_cyc1.size()), 32'd0);
    chk("mr_idle",      32'(busy),             32'd0);
    in_data = 8'h77; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    tick();
    chk("mr_new_data", 32'(link_data), 32'h77);
    repeat (8) tick();
    chk("mr_new_rises", 32'(rise_cyc1.size()), 32'd1);
    if (rise_dat1.size() == 1) chk("mr_new_rdata", 32'(rise_dat1[0]), 32'h77);
    clear_mon();

    // Parameter sweep instance: SETUP=1, HIGH=3, GAP=1
    in_data2 = 8'h5A; in_valid2 = 1'b1; tick();
    in_data2 = 8'h6B; tick();
    in_valid2 = 1'b0;
    repeat (20) tick();
    chk("ps_rises", 32'(rise_cyc2.size()), 32'd2);
    chk("ps_highs", 32'(hi_w2.size()),     32'd2);
    if (rise_cyc2.size() == 2 && hi_w2.size() == 2) begin
      chk("ps_period", 32'(rise_cyc2[1] - rise_cyc2[0]), 32'd5);
      chk("ps_width0", 32'(hi_w2[0]), 32'd3);
      chk("ps_width1", 32'(hi_w2[1]), 32'd3);
      chk("ps_data0",  32'(rise_dat2[0]), 32'h5A);
      chk("ps_data1",  32'(rise_dat2[1]), 32'h6B);
    end
    chk("ps_idle", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
